// File: rtl/dmem_arbiter_if.sv
// Memory-stage / DMA / data-memory signal bundle for dmem_arbiter; master = requesters + memory, slave = arbiter.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          dma_valid;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_last;
    logic          dma_ready;
    logic [DW-1:0] dma_rdata;
    logic          dma_rvalid;

    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    logic [31:0]   stat_cpu_stall_cnt;
    logic [31:0]   stat_dma_beats;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_valid, dma_we, dma_addr, dma_wdata, dma_last,
        input  dma_ready, dma_rdata, dma_rvalid,
        input  mem_a, mem_wd, mem_we,
        output mem_rd,
        input  stat_cpu_stall_cnt, stat_dma_beats
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_valid, dma_we, dma_addr, dma_wdata, dma_last,
        output dma_ready, dma_rdata, dma_rvalid,
        output mem_a, mem_wd, mem_we,
        input  mem_rd,
        output stat_cpu_stall_cnt, stat_dma_beats
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the pipeline (zero-latency owner) and a bursting DMA port; DMA reads return 1 cycle later.
// Backpressure: cpu_stall / dma_ready, both starvation-guarded. Stat counters built only with DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    dmem_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, DMA, CPU_PRIO} state_t;

    state_t        state, state_nx;
    logic [BW-1:0] beat_cnt, beat_cnt_nx;
    logic [WW-1:0] dma_wait, cpu_wait;
    logic          dma_rdy, dma_acc, cpu_gnt, cpu_stall;
    logic          dma_starved, cpu_starved;
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;
    logic [AW-1:0] mux_a;

    assign dma_starved = (dma_wait == WW'(STARVE_LIMIT));
    assign cpu_starved = (cpu_wait == WW'(STARVE_LIMIT));

    always_comb begin
        state_nx    = state;
        beat_cnt_nx = beat_cnt;
        dma_rdy     = 1'b0;
        cpu_gnt     = 1'b0;
        case (state)
            IDLE: begin
                dma_rdy = bus.dma_valid & (~bus.cpu_req | dma_starved);
                cpu_gnt = bus.cpu_req & ~dma_rdy;
                if (dma_rdy) begin
                    beat_cnt_nx = BW'(1);
                    state_nx    = (bus.dma_last || MAX_BURST == 1) ? CPU_PRIO : DMA;
                end
            end
            DMA: begin
                dma_rdy = 1'b1;
                if (bus.dma_valid) begin
                    beat_cnt_nx = beat_cnt + BW'(1);
                    if (bus.dma_last || beat_cnt_nx == BW'(MAX_BURST) || cpu_starved)
                        state_nx = CPU_PRIO;
                end else begin
                    // a bubble hands the memory straight back to the pipeline
                    cpu_gnt  = bus.cpu_req;
                    state_nx = IDLE;
                end
            end
            CPU_PRIO: begin
                cpu_gnt  = bus.cpu_req;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (!rst) begin
            dma_rdy = 1'b0;
            cpu_gnt = 1'b0;
        end
    end

    assign dma_acc   = dma_rdy & bus.dma_valid;
    assign cpu_stall = bus.cpu_req & ~cpu_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            dma_wait <= '0;
            cpu_wait <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_cnt_nx;
            if (dma_acc)
                dma_wait <= '0;
            else if (bus.dma_valid && !dma_rdy && !dma_starved)
                dma_wait <= dma_wait + WW'(1);
            if (cpu_gnt)
                cpu_wait <= '0;
            else if (cpu_stall && !cpu_starved)
                cpu_wait <= cpu_wait + WW'(1);
            rvalid_q <= dma_acc & ~bus.dma_we;
            if (dma_acc && !bus.dma_we)
                rdata_q <= bus.mem_rd;
        end
    end

    assign mux_a          = dma_acc ? bus.dma_addr : bus.cpu_addr;
    assign bus.mem_a      = mux_a;
    assign bus.mem_wd     = dma_acc ? bus.dma_wdata : bus.cpu_wdata;
    assign bus.mem_we     = dma_acc ? bus.dma_we : (cpu_gnt & bus.cpu_we);
    assign bus.cpu_rdata  = bus.mem_rd;
    assign bus.cpu_stall  = cpu_stall;
    assign bus.dma_ready  = dma_rdy;
    assign bus.dma_rdata  = rdata_q;
    assign bus.dma_rvalid = rvalid_q;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cnt, beat_total;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            beat_total <= '0;
        end else begin
            if (cpu_stall && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (dma_acc && beat_total != 32'hFFFF_FFFF)
                beat_total <= beat_total + 32'd1;
        end
    end

    assign bus.stat_cpu_stall_cnt = stall_cnt;
    assign bus.stat_dma_beats     = beat_total;
`else
    assign bus.stat_cpu_stall_cnt = 32'd0;
    assign bus.stat_dma_beats     = 32'd0;
`endif
endmodule
